transform_quant_pipe: RTL
=========================

TRANSFORM_QUANT_PIPE -- requirements
Module: transform_quant_pipe

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 15: MSB index of every signed sample; sample width is BIT_LENGTH+1.
REQ-002 SHALL have parameter QP_MAX, default 51: largest legal QP.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = pipeline may advance; low = all state frozen.
REQ-006 in_valid  input  1  residual block offered.
REQ-007 in_ready  output  1  block accepted when in_valid && in_ready.
REQ-008 residuals  input  16 x (BIT_LENGTH+1)  signed residuals, element index 4*row+col.
REQ-009 qp  input  6  quantisation parameter, sampled with the block.
REQ-010 mode  input  1  1 = intra rounding, 0 = inter rounding, sampled with the block.
REQ-011 out_valid  output  1  quantised block present.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 quantized  output  16 x (BIT_LENGTH+1)  signed levels, same indexing.
REQ-014 nz_count  output  5  number of nonzero levels (0..16).
REQ-015 coded  output  1  high iff nz_count != 0.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 row 4-point forward integer transform, S2 column transform, S3 quantisation; latency exactly 3 cycles from acceptance to out_valid with no stall.
REQ-017 1-D transform: y0=x0+x1+x2+x3, y1=2x0+x1-x2-2x3, y2=x0-x1-x2+x3, y3=x0-2x1+2x2-x3.
REQ-018 Internal transform width SHALL be BIT_LENGTH+7 signed; no overflow possible.
REQ-019 qp > QP_MAX SHALL be clamped to QP_MAX; qp_by_6 = qp/6, qp_mod_6 = qp%6, computed on acceptance and carried with the block.
REQ-020 qbits = 15 + qp_by_6; f = floor(2^qbits/3) intra, floor(2^qbits/6) inter.
REQ-021 MF class A (both row and col even): 13107,11916,10082,9362,8192,7282; class B (both odd): 5243,4660,4194,3647,3355,2893; class C (otherwise): 8066,7490,6554,5825,5243,4559; indexed by qp_mod_6.
REQ-022 level = sign(W) * ((|W|*MF + f) >> qbits); zero maps to zero.
REQ-023 Levels outside the signed BIT_LENGTH+1 range SHALL saturate to max/min.
REQ-024 nz_count and coded SHALL be valid in the same cycle as the matching quantized.
REQ-025 advance = enable && (!out_valid || out_ready); in_ready = advance; every stage moves when advance is high; bubbles propagate as invalid.
REQ-026 While out_valid && !out_ready, outputs SHALL hold stable; no block lost, duplicated or reordered.
REQ-027 Throughput one block per cycle with out_ready held high.
REQ-028 enable low SHALL freeze all registers, in_ready low, outputs held.
REQ-029 Simultaneous output accept and input accept in one cycle SHALL both take effect.

Reset
REQ-030 reset low SHALL asynchronously clear all stage valids, out_valid, quantized, nz_count, coded and qp/mode side registers to 0.
REQ-031 Reset mid-operation discards all in-flight blocks; first acceptance allowed the first clk edge after release with enable high.
REQ-032 in_ready SHALL be 0 while reset is low.

Structure
REQ-033 Package tc_pkg SHALL hold the MF tables, rounding divisors, QP_MAX default and the position-class function.
REQ-034 One sub-module tran_1d_4pt (4-point butterfly, parametrised width), instantiated 4x in S1 and 4x in S2.
REQ-035 Target 120-400 RTL lines.

Verification
REQ-036 All-zero block, qp=20, intra -> quantized all 0, nz_count=0, coded=0, out_valid 3 cycles after accept.
REQ-037 All residuals +1, qp=0, intra -> quantized[0]=6, others 0, nz_count=1; all -1 -> quantized[0]=-6; inter, all +1 -> quantized[0]=6.
REQ-038 qp=63 -> behaves identically to qp=51; max-magnitude residuals at qp=0 -> saturated levels, no wrap.
REQ-039 4 back-to-back blocks, out_ready low for 2 cycles mid-stream -> in_ready drops, all 4 blocks emerge in order, outputs stable while stalled.
REQ-040 reset pulsed low with 3 blocks in flight -> out_valid 0 immediately, no stale block ever emitted after release.
REQ-041 enable low 5 cycles mid-stream -> no state change, stream resumes intact; random blocks/qp/mode versus a reference model -> bit-exact.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared constants for the 4x4 transform/quantiser: MF tables, rounding divisors, QP limit
// and the coefficient position-class helper.
package tc_pkg;

    localparam int QP_MAX_DEF    = 51;
    localparam int QBITS_BASE    = 15;
    localparam int RND_DIV_INTRA = 3;
    localparam int RND_DIV_INTER = 6;
    localparam int QDW           = 4;

    typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} pos_cls_e;
    typedef logic [13:0] mf_t;

    // Element 0 is the rightmost entry, so each table reads qp%6 = 5 .. 0 left to right.
    localparam logic [5:0][13:0] MF_A = {14'd7282, 14'd8192, 14'd9362, 14'd10082, 14'd11916, 14'd13107};
    localparam logic [5:0][13:0] MF_B = {14'd2893, 14'd3355, 14'd3647, 14'd4194, 14'd4660, 14'd5243};
    localparam logic [5:0][13:0] MF_C = {14'd4559, 14'd5243, 14'd5825, 14'd6554, 14'd7490, 14'd8066};

    function automatic pos_cls_e pos_class(input logic [1:0] row, input logic [1:0] col);
        if (!row[0] && !col[0]) return CLS_A;
        if (row[0] && col[0])   return CLS_B;
        return CLS_C;
    endfunction

    function automatic mf_t mf_lookup(input pos_cls_e cls, input logic [2:0] qp_mod);
        logic [2:0] m;
        m = (qp_mod > 3'd5) ? 3'd5 : qp_mod;
        case (cls)
            CLS_A:   return MF_A[m];
            CLS_B:   return MF_B[m];
            default: return MF_C[m];
        endcase
    endfunction

endpackage

// File: rtl/tran_1d_4pt.sv
// 4-point forward integer butterfly; purely combinational, no backpressure.
// Caller sizes WIDTH so the x6 gain cannot overflow.
module tran_1d_4pt #(
    parameter int WIDTH = 22
) (
    input  logic signed [WIDTH-1:0] i_x0,
    input  logic signed [WIDTH-1:0] i_x1,
    input  logic signed [WIDTH-1:0] i_x2,
    input  logic signed [WIDTH-1:0] i_x3,
    output logic signed [WIDTH-1:0] o_y0,
    output logic signed [WIDTH-1:0] o_y1,
    output logic signed [WIDTH-1:0] o_y2,
    output logic signed [WIDTH-1:0] o_y3
);
    assign o_y0 = i_x0 + i_x1 + i_x2 + i_x3;
    assign o_y1 = (i_x0 <<< 1) + i_x1 - i_x2 - (i_x3 <<< 1);
    assign o_y2 = i_x0 - i_x1 - i_x2 + i_x3;
    assign o_y3 = i_x0 - (i_x1 <<< 1) + (i_x2 <<< 1) - i_x3;
endmodule

// File: rtl/transform_quant_pipe.sv
// 4x4 residual block -> row transform, column transform, quantisation; 3-cycle latency.
// Whole pipeline advances only when enabled and the output register is empty or being drained.
module transform_quant_pipe
    import tc_pkg::*;
#(
    parameter int BIT_LENGTH = 15,
    parameter int QP_MAX     = QP_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0][BIT_LENGTH:0]  residuals,
    input  logic [5:0]                 qp,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0][BIT_LENGTH:0]  quantized,
    output logic [4:0]                 nz_count,
    output logic                       coded
);
    localparam int TW = BIT_LENGTH + 7;
    localparam int PW = TW + 24;
    localparam logic [BIT_LENGTH:0] SMAX = {1'b0, {BIT_LENGTH{1'b1}}};
    localparam logic [BIT_LENGTH:0] SMIN = {1'b1, {BIT_LENGTH{1'b0}}};

    logic                 w_adv;
    logic [5:0]           w_qp_c;
    logic [QDW-1:0]       w_qp_div;
    logic [2:0]           w_qp_mod;
    logic signed [TW-1:0] w_row [16];
    logic signed [TW-1:0] w_col [16];
    logic [15:0][BIT_LENGTH:0] w_q;
    logic [4:0]           w_nz;

    logic                 r_s1_vld, r_s2_vld;
    logic                 r_s1_mode, r_s2_mode;
    logic [QDW-1:0]       r_s1_div, r_s2_div;
    logic [2:0]           r_s1_mod, r_s2_mod;
    logic signed [TW-1:0] r_s1_dat [16];
    logic signed [TW-1:0] r_s2_dat [16];

    assign w_adv    = enable && (!out_valid || out_ready);
    assign in_ready = w_adv && reset;

    assign w_qp_c   = (int'(qp) > QP_MAX) ? 6'(QP_MAX) : qp;
    assign w_qp_div = QDW'(w_qp_c / 6'd6);
    assign w_qp_mod = 3'(w_qp_c % 6'd6);

    for (genvar r = 0; r < 4; r++) begin : g_row
        tran_1d_4pt #(.WIDTH(TW)) u_row (
            .i_x0(TW'($signed(residuals[4*r+0]))),
            .i_x1(TW'($signed(residuals[4*r+1]))),
            .i_x2(TW'($signed(residuals[4*r+2]))),
            .i_x3(TW'($signed(residuals[4*r+3]))),
            .o_y0(w_row[4*r+0]),
            .o_y1(w_row[4*r+1]),
            .o_y2(w_row[4*r+2]),
            .o_y3(w_row[4*r+3])
        );
    end

    // Column pass: output k of column c lands at row k, col c.
    for (genvar c = 0; c < 4; c++) begin : g_col
        tran_1d_4pt #(.WIDTH(TW)) u_col (
            .i_x0(r_s1_dat[c]),
            .i_x1(r_s1_dat[4+c]),
            .i_x2(r_s1_dat[8+c]),
            .i_x3(r_s1_dat[12+c]),
            .o_y0(w_col[c]),
            .o_y1(w_col[4+c]),
            .o_y2(w_col[8+c]),
            .o_y3(w_col[12+c])
        );
    end

    always_comb begin
        logic [5:0]    v_qbits;
        logic [PW-1:0] v_pow, v_f, v_mag, v_lvl;
        logic          v_neg;
        v_qbits = 6'(QBITS_BASE) + 6'(r_s2_div);
        v_pow   = PW'(1) << v_qbits;
        v_f     = r_s2_mode ? v_pow / PW'(RND_DIV_INTRA) : v_pow / PW'(RND_DIV_INTER);
        v_mag   = '0;
        v_lvl   = '0;
        v_neg   = 1'b0;
        w_q     = '0;
        w_nz    = '0;
        for (int i = 0; i < 16; i++) begin
            v_neg = r_s2_dat[i][TW-1];
            v_mag = PW'(v_neg ? -r_s2_dat[i] : r_s2_dat[i]);
            v_lvl = (v_mag * PW'(mf_lookup(pos_class(2'(i >> 2), 2'(i & 3)), r_s2_mod)) + v_f) >> v_qbits;
            if (!v_neg)
                w_q[i] = (v_lvl > PW'(SMAX)) ? SMAX : v_lvl[BIT_LENGTH:0];
            else
                w_q[i] = (v_lvl > PW'(SMIN)) ? SMIN : -v_lvl[BIT_LENGTH:0];
            w_nz = w_nz + 5'(w_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_div  <= '0;
            r_s1_mod  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_div  <= '0;
            r_s2_mod  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_s1_dat[i] <= '0;
                r_s2_dat[i] <= '0;
            end
            out_valid <= 1'b0;
            quantized <= '0;
            nz_count  <= '0;
            coded     <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= in_valid;
            r_s1_mode <= mode;
            r_s1_div  <= w_qp_div;
            r_s1_mod  <= w_qp_mod;
            r_s2_vld  <= r_s1_vld;
            r_s2_mode <= r_s1_mode;
            r_s2_div  <= r_s1_div;
            r_s2_mod  <= r_s1_mod;
            for (int i = 0; i < 16; i++) begin
                r_s1_dat[i] <= w_row[i];
                r_s2_dat[i] <= w_col[i];
            end
            out_valid <= r_s2_vld;
            quantized <= w_q;
            nz_count  <= w_nz;
            coded     <= (w_nz != '0);
        end
    end

endmodule
